// File: rtl/sched_biquad.sv
// Round-robin scheduler that time-multiplexes one biquad MAC datapath between
// N_CANALES filter channels. Each grant runs a fixed step sequence:
// CLR, MAC steps, LEER (state write), remaining MAC steps, OUT, DESP.
module sched_biquad #(
  parameter int unsigned N_CANALES = 3,
  parameter int unsigned W_CH      = 2,
  parameter int unsigned N_PASOS   = 6,
  parameter int unsigned PASO_LEER = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,     // asynchronous, active-low
  input  logic [N_CANALES-1:0] i_req,
  output logic [W_CH-1:0]      o_ch,
  output logic [3:0]           o_sel,
  output logic                 o_rst_acum,
  output logic                 o_leer,
  output logic                 o_leer_y,
  output logic                 o_desp,
  output logic                 o_ocupado,
  output logic [N_CANALES-1:0] o_ovr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_MAC_A = 3'd2;  // MAC steps before the state write
  localparam logic [2:0] ST_LEER  = 3'd3;
  localparam logic [2:0] ST_MAC_B = 3'd4;  // MAC steps after the state write
  localparam logic [2:0] ST_OUT   = 3'd5;
  localparam logic [2:0] ST_DESP  = 3'd6;

  localparam logic [3:0] SEL_LEER = 4'(PASO_LEER - 1);
  localparam logic [3:0] SEL_LAST = 4'(N_PASOS - 1);
  localparam logic [3:0] SEL_B0   = 4'(PASO_LEER);

  logic [2:0]           r_state;
  logic [3:0]           r_sel;
  logic [W_CH-1:0]      r_ch;
  logic [W_CH-1:0]      r_ptr;
  logic [N_CANALES-1:0] r_pend;
  logic [N_CANALES-1:0] r_ovr;
  logic                 r_rst_acum;
  logic                 r_leer;
  logic                 r_leer_y;
  logic                 r_desp;
  logic                 r_ocupado;

  logic                 w_hay;
  logic [W_CH-1:0]      w_win;
  logic [W_CH-1:0]      w_idx;
  logic                 w_grant;
  logic [2:0]           w_state_d;
  logic [3:0]           w_sel_d;
  logic [W_CH-1:0]      w_ch_d;
  logic [N_CANALES-1:0] w_clr;

  // Round-robin arbiter: first pending channel searching from r_ptr+1 with wrap.
  always_comb begin
    w_hay = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= int'(N_CANALES); k++) begin
      w_idx = W_CH'((int'(r_ptr) + k) % int'(N_CANALES));
      if (!w_hay && r_pend[w_idx]) begin
        w_hay = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Step sequencer next-state; a grant can start from IDLE or straight from DESP.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_ch_d    = r_ch;
    w_grant   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hay) w_grant = 1'b1;
      end
      ST_CLR: begin
        w_state_d = ST_MAC_A;
        w_sel_d   = '0;
      end
      ST_MAC_A: begin
        if (r_sel == SEL_LEER) w_state_d = ST_LEER;
        else w_sel_d = r_sel + 4'd1;
      end
      ST_LEER: begin
        w_state_d = ST_MAC_B;
        w_sel_d   = SEL_B0;
      end
      ST_MAC_B: begin
        if (r_sel == SEL_LAST) w_state_d = ST_OUT;
        else w_sel_d = r_sel + 4'd1;
      end
      ST_OUT: begin
        w_state_d = ST_DESP;
      end
      ST_DESP: begin
        if (w_hay) begin
          w_grant = 1'b1;
        end else begin
          w_state_d = ST_IDLE;
          w_sel_d   = '0;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_sel_d   = '0;
      end
    endcase
    if (w_grant) begin
      w_state_d = ST_CLR;
      w_sel_d   = '0;
      w_ch_d    = w_win;
    end
  end

  // Grant clears the winner's pending bit; a simultaneous request re-arms it.
  always_comb begin
    w_clr = w_grant ? (N_CANALES'(1) << w_win) : '0;
  end

  // State, request bookkeeping and registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ch       <= '0;
      r_ptr      <= W_CH'(N_CANALES - 1);
      r_pend     <= '0;
      r_ovr      <= '0;
      r_rst_acum <= 1'b0;
      r_leer     <= 1'b0;
      r_leer_y   <= 1'b0;
      r_desp     <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_sel      <= w_sel_d;
      r_ch       <= w_ch_d;
      if (w_grant) r_ptr <= w_win;
      r_pend     <= (r_pend & ~w_clr) | i_req;
      // A request hitting a pending bit that is not being granted is lost.
      r_ovr      <= r_ovr | (i_req & r_pend & ~w_clr);
      r_rst_acum <= (w_state_d == ST_CLR);
      r_leer     <= (w_state_d == ST_LEER);
      r_leer_y   <= (w_state_d == ST_OUT);
      r_desp     <= (w_state_d == ST_DESP);
      r_ocupado  <= (w_state_d != ST_IDLE);
    end
  end

  assign o_ch       = r_ch;
  assign o_sel      = r_sel;
  assign o_rst_acum = r_rst_acum;
  assign o_leer     = r_leer;
  assign o_leer_y   = r_leer_y;
  assign o_desp     = r_desp;
  assign o_ocupado  = r_ocupado;
  assign o_ovr      = r_ovr;

endmodule

// File: tb/tb_sched_biquad.sv
// Directed bench for sched_biquad: expected (channel, cycle) of every leer_y
// pulse is queued when stimulus is driven and popped when the DUT pulses.
module tb_sched_biquad;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [1:0] ch;
  logic [3:0] sel;
  logic       rst_acum, leer, leer_y, desp, ocupado;
  logic [2:0] ovr;

  sched_biquad #(
    .N_CANALES(3),
    .W_CH     (2),
    .N_PASOS  (6),
    .PASO_LEER(3)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .o_ch      (ch),
    .o_sel     (sel),
    .o_rst_acum(rst_acum),
    .o_leer    (leer),
    .o_leer_y  (leer_y),
    .o_desp    (desp),
    .o_ocupado (ocupado),
    .o_ovr     (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k;
  int   cnt;

  // Expected sel / {rst_acum,leer,leer_y,desp,ocupado} for CLR..DESP.
  logic [3:0] exp_sel [10] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
  logic [4:0] exp_fl  [10] = '{5'b10001, 5'b00001, 5'b00001, 5'b00001, 5'b01001,
                               5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] c, input int at);
    exp_t e;
    e.ch  = c;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // One clock: count the edge, then look at outputs on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("pulse_excl", 32'($countones({rst_acum, leer, leer_y, desp}) <= 1), 32'd1);
    if (leer_y) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_leer_y", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_ch", 32'(ch), 32'(e.ch));
        chk("sb_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic pulse(input logic [2:0] v);
    req = v;
    step();
    req = '0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_outs", 32'({ch, sel, rst_acum, leer, leer_y, desp, ocupado, ovr}), 32'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    do_reset();

    // Single request on channel 0: full step sequence.
    pulse(3'b001);
    k = cyc;
    push(2'd0, k + 9);
    for (int j = 0; j < 10; j++) begin
      step();
      if (j != 9) chk("t1_sel", 32'(sel), 32'(exp_sel[j]));
      chk("t1_flags", 32'({rst_acum, leer, leer_y, desp, ocupado}), 32'(exp_fl[j]));
      chk("t1_ch", 32'(ch), 32'd0);
    end
    step();
    chk("t1_idle", 32'(ocupado), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // All three channels at once from reset: 0,1,2 back-to-back.
    do_reset();
    pulse(3'b111);
    k = cyc;
    push(2'd0, k + 9);
    push(2'd1, k + 19);
    push(2'd2, k + 29);
    cnt = 0;
    for (int j = 0; j < 31; j++) begin
      step();
      if (ocupado) cnt++;
    end
    chk("t2_busy_cycles", 32'(cnt), 32'd30);
    chk("t2_ovr", 32'(ovr), 32'd0);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Pointer at 0: with 0 and 1 pending, 1 wins first.
    do_reset();
    pulse(3'b001);
    k = cyc;
    push(2'd0, k + 9);
    run(11);
    pulse(3'b011);
    k = cyc;
    push(2'd1, k + 9);
    push(2'd0, k + 19);
    run(21);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Double request on ch1 while ch2 is in service: overrun on ch1 only.
    do_reset();
    pulse(3'b100);
    k = cyc;
    push(2'd2, k + 9);
    push(2'd1, k + 19);
    step();
    chk("t4_ch_service", 32'(ch), 32'd2);
    pulse(3'b010);
    pulse(3'b010);
    chk("t4_ovr_set", 32'(ovr), 32'b010);
    run(29);
    chk("t4_ovr_hold", 32'(ovr), 32'b010);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    do_reset();
    chk("t4_ovr_cleared", 32'(ovr), 32'd0);

    // Request coinciding with its own grant: served twice, no overrun.
    req = 3'b100;
    step();
    k = cyc;
    step();
    req = '0;
    push(2'd2, k + 9);
    push(2'd2, k + 19);
    run(22);
    chk("t5_ovr", 32'(ovr), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during MAC_4 aborts the sequence and drops pending requests.
    do_reset();
    pulse(3'b001);
    k = cyc;
    pulse(3'b010);
    run(6);
    chk("t6_in_mac4", 32'(sel), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'({ch, sel, rst_acum, leer, leer_y, desp, ocupado, ovr}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (ocupado || desp || leer_y) cnt++;
    end
    chk("t6_no_activity", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
